// File: rtl/rf_write_arbiter_if.sv
// Writeback request bundle for rf_write_arbiter: two valid/ready ports (0 = ALU, 1 = MEM).
// Requesters drive through the master modport; the arbiter takes the slave modport.
interface rf_write_arbiter_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 4
);
    logic          req0_valid;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_data;
    logic          req0_ready;

    logic          req1_valid;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_data;
    logic          req1_ready;

    modport master (
        output req0_valid, req0_addr, req0_data,
        input  req0_ready,
        output req1_valid, req1_addr, req1_data,
        input  req1_ready
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        output req0_ready,
        input  req1_valid, req1_addr, req1_data,
        output req1_ready
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between the ALU (port 0) and MEM (port 1) writebacks.
// Build option: RF_WARB_RR_EN selects round-robin for different-address conflicts (else ALU wins).
module rf_write_arbiter #(
    parameter int unsigned DW   = 32,
    parameter int unsigned AW   = 4,
    parameter int unsigned CNTW = 8
) (
    input  logic                  Clk,
    input  logic                  Clr,
    rf_write_arbiter_if.slave     req,
    output logic                  rf_ld,
    output logic [AW-1:0]         rf_addr,
    output logic [DW-1:0]         rf_data,
    output logic [(1<<AW)-1:0]    busy,
    output logic [CNTW-1:0]       stall_cnt
);
    localparam int unsigned NREG = 1 << AW;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_P0   = 2'd1,
        GNT_P1   = 2'd2
    } gnt_e;

    // Holding buffers
    logic          full0_q, full1_q;
    logic [AW-1:0] addr0_q, addr1_q;
    logic [DW-1:0] data0_q, data1_q;
    // 1: port 1 holds the older write, 0: port 0 does
    logic          age_q;

    logic          full0_d, full1_d;
    logic [AW-1:0] addr0_d, addr1_d;
    logic [DW-1:0] data0_d, data1_d;
    logic          age_d;

    logic          rf_ld_d;
    logic [AW-1:0] rf_addr_d;
    logic [DW-1:0] rf_data_d;
    logic [CNTW-1:0] stall_d;

    gnt_e          gnt;
    logic          grant0, grant1;
    logic          acc0, acc1;
    logic          keep0, keep1;

`ifdef RF_WARB_RR_EN
    logic          rr_q, rr_d;
    logic          conflict_diff;
`endif

    // Arbitration: single full buffer wins; same-address pair goes by age
    always_comb begin
        gnt = GNT_NONE;
        if (full0_q && full1_q) begin
            if (addr0_q == addr1_q) begin
                gnt = age_q ? GNT_P1 : GNT_P0;
            end else begin
`ifdef RF_WARB_RR_EN
                gnt = rr_q ? GNT_P1 : GNT_P0;
`else
                gnt = GNT_P0;
`endif
            end
        end else if (full0_q) begin
            gnt = GNT_P0;
        end else if (full1_q) begin
            gnt = GNT_P1;
        end
    end

    assign grant0 = (gnt == GNT_P0);
    assign grant1 = (gnt == GNT_P1);

    // A buffer being drained this edge can take a new entry at the same edge
    assign req.req0_ready = !full0_q || grant0;
    assign req.req1_ready = !full1_q || grant1;

    assign acc0  = req.req0_valid && req.req0_ready;
    assign acc1  = req.req1_valid && req.req1_ready;
    assign keep0 = full0_q && !grant0;
    assign keep1 = full1_q && !grant1;

`ifdef RF_WARB_RR_EN
    assign conflict_diff = full0_q && full1_q && (addr0_q != addr1_q);
`endif

    // Next-state for buffers, age flag, write port and stall counter
    always_comb begin
        full0_d   = acc0 || keep0;
        full1_d   = acc1 || keep1;
        addr0_d   = acc0 ? req.req0_addr : addr0_q;
        data0_d   = acc0 ? req.req0_data : data0_q;
        addr1_d   = acc1 ? req.req1_addr : addr1_q;
        data1_d   = acc1 ? req.req1_data : data1_q;
        age_d     = age_q;
        rf_ld_d   = 1'b0;
        rf_addr_d = rf_addr;
        rf_data_d = rf_data;
        stall_d   = stall_cnt;

        // The entry that stays put is older than a fresh one; a tie favours MEM
        if (acc0 && keep1) begin
            age_d = 1'b1;
        end else if (acc1 && keep0) begin
            age_d = 1'b0;
        end else if (acc0 && acc1) begin
            age_d = 1'b1;
        end

        if (grant0) begin
            rf_ld_d   = 1'b1;
            rf_addr_d = addr0_q;
            rf_data_d = data0_q;
        end else if (grant1) begin
            rf_ld_d   = 1'b1;
            rf_addr_d = addr1_q;
            rf_data_d = data1_q;
        end

        if ((keep0 || keep1) && (stall_cnt != {CNTW{1'b1}})) begin
            stall_d = stall_cnt + CNTW'(1);
        end
    end

`ifdef RF_WARB_RR_EN
    // Preference flips only after a different-address conflict is resolved
    always_comb begin
        rr_d = rr_q;
        if (conflict_diff) begin
            rr_d = ~rr_q;
        end
    end

    always_ff @(posedge Clk) begin
        if (Clr) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    always_ff @(posedge Clk) begin
        if (Clr) begin
            full0_q   <= 1'b0;
            full1_q   <= 1'b0;
            addr0_q   <= '0;
            addr1_q   <= '0;
            data0_q   <= '0;
            data1_q   <= '0;
            age_q     <= 1'b0;
            rf_ld     <= 1'b0;
            rf_addr   <= '0;
            rf_data   <= '0;
            stall_cnt <= '0;
        end else begin
            full0_q   <= full0_d;
            full1_q   <= full1_d;
            addr0_q   <= addr0_d;
            addr1_q   <= addr1_d;
            data0_q   <= data0_d;
            data1_q   <= data1_d;
            age_q     <= age_d;
            rf_ld     <= rf_ld_d;
            rf_addr   <= rf_addr_d;
            rf_data   <= rf_data_d;
            stall_cnt <= stall_d;
        end
    end

    // Pending-write scoreboard for decode hazard checks
    always_comb begin
        busy = '0;
        if (full0_q) begin
            busy = busy | (NREG'(1) << addr0_q);
        end
        if (full1_q) begin
            busy = busy | (NREG'(1) << addr1_q);
        end
        if (rf_ld) begin
            busy = busy | (NREG'(1) << rf_addr);
        end
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: expected writes are queued at stimulus time
// and popped by a monitor on every rf_ld cycle; a small regfile model tracks commits.
module tb_rf_write_arbiter;
    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 4;
    localparam int unsigned CNTW = 8;
`ifdef RF_WARB_RR_EN
    localparam int BLOCK_CYC = 1;
`else
    localparam int BLOCK_CYC = 4;
`endif

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic            Clk;
    logic            Clr;
    logic            rf_ld;
    logic [AW-1:0]   rf_addr;
    logic [DW-1:0]   rf_data;
    logic [15:0]     busy;
    logic [CNTW-1:0] stall_cnt;

    rf_write_arbiter_if #(.DW(DW), .AW(AW)) bus ();

    rf_write_arbiter #(.DW(DW), .AW(AW), .CNTW(CNTW)) dut (
        .Clk       (Clk),
        .Clr       (Clr),
        .req       (bus),
        .rf_ld     (rf_ld),
        .rf_addr   (rf_addr),
        .rf_data   (rf_data),
        .busy      (busy),
        .stall_cnt (stall_cnt)
    );

    int    checks = 0;
    int    errors = 0;
    wr_t   exp_q[$];
    wr_t   mon_e;
    logic  mon_en = 1'b1;
    logic [DW-1:0] rf_mem [16];

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Regfile model: commits one edge after rf_ld is seen
    always @(posedge Clk) begin
        if (rf_ld === 1'b1) rf_mem[rf_addr] <= rf_data;
    end

    always @(negedge Clk) begin
        if (mon_en && rf_ld === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", rf_addr, rf_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (rf_addr !== mon_e.addr || rf_data !== mon_e.data) begin
                    errors++;
                    $display("FAIL write_order: got addr=%0d data=%h, required addr=%0d data=%h",
                             rf_addr, rf_data, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge Clk);
        Clr = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge Clk);
        Clr = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 64) begin
            @(negedge Clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d writes outstanding, required 0", exp_q.size());
        end
        repeat (2) @(negedge Clk);
    endtask

    task automatic send0(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        n = 0;
        bus.req0_valid = 1'b1;
        bus.req0_addr  = a;
        bus.req0_data  = d;
        while (bus.req0_ready !== 1'b1 && n < 64) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 64) begin
            checks++;
            errors++;
            $display("FAIL send0_timeout: ready=%b, required 1", bus.req0_ready);
        end
        @(negedge Clk);
    endtask

    task automatic send1(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        n = 0;
        bus.req1_valid = 1'b1;
        bus.req1_addr  = a;
        bus.req1_data  = d;
        while (bus.req1_ready !== 1'b1 && n < 64) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 64) begin
            checks++;
            errors++;
            $display("FAIL send1_timeout: ready=%b, required 1", bus.req1_ready);
        end
        @(negedge Clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (rf_ld !== 1'b0) begin errors++; $display("FAIL reset_rf_ld: got %b, required 0", rf_ld); end
        checks++;
        if (busy !== 16'h0000) begin errors++; $display("FAIL reset_busy: got %h, required 0000", busy); end
        checks++;
        if (stall_cnt !== 8'd0) begin errors++; $display("FAIL reset_stall: got %0d, required 0", stall_cnt); end
        checks++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b%b, required 11", bus.req0_ready, bus.req1_ready);
        end
    endtask

    task automatic test_single();
        do_reset();
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 4'd8;
        bus.req0_data  = 32'h10;
        exp_q.push_back('{addr: 4'd8, data: 32'h10});
        @(negedge Clk);
        bus.req0_valid = 1'b0;
        checks++;
        if (rf_ld !== 1'b0 || busy !== 16'h0100) begin
            errors++;
            $display("FAIL single_buffered: got rf_ld=%b busy=%h, required 0 0100", rf_ld, busy);
        end
        @(negedge Clk);
        checks++;
        if (rf_ld !== 1'b1 || rf_addr !== 4'd8 || rf_data !== 32'h10 || busy !== 16'h0100) begin
            errors++;
            $display("FAIL single_issue: got ld=%b addr=%0d data=%h busy=%h, required 1 8 00000010 0100",
                     rf_ld, rf_addr, rf_data, busy);
        end
        @(negedge Clk);
        checks++;
        if (rf_ld !== 1'b0 || busy !== 16'h0000) begin
            errors++;
            $display("FAIL single_done: got rf_ld=%b busy=%h, required 0 0000", rf_ld, busy);
        end
        checks++;
        if (rf_mem[8] !== 32'h10) begin
            errors++;
            $display("FAIL single_commit: got R8=%h, required 00000010", rf_mem[8]);
        end
    endtask

    task automatic test_same_addr();
        do_reset();
        exp_q.push_back('{addr: 4'd3, data: 32'hB});
        exp_q.push_back('{addr: 4'd3, data: 32'hA});
        fork
            begin send0(4'd3, 32'hA); bus.req0_valid = 1'b0; end
            begin send1(4'd3, 32'hB); bus.req1_valid = 1'b0; end
        join
        wait_drain();
        checks++;
        if (rf_mem[3] !== 32'hA) begin
            errors++;
            $display("FAIL same_addr_final: got R3=%h, required 0000000a", rf_mem[3]);
        end
        checks++;
        if (stall_cnt !== 8'd1) begin
            errors++;
            $display("FAIL same_addr_stall: got %0d, required 1", stall_cnt);
        end
    endtask

    task automatic test_conflict();
        do_reset();
`ifdef RF_WARB_RR_EN
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{addr: 4'd1, data: 32'h11});
            exp_q.push_back('{addr: 4'd2, data: 32'h22});
        end
`else
        for (int i = 0; i < 4; i++) exp_q.push_back('{addr: 4'd1, data: 32'h11});
        for (int i = 0; i < 4; i++) exp_q.push_back('{addr: 4'd2, data: 32'h22});
`endif
        fork
            begin
                for (int i = 0; i < 4; i++) send0(4'd1, 32'h11);
                bus.req0_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 4; i++) send1(4'd2, 32'h22);
                bus.req1_valid = 1'b0;
            end
            begin
                for (int k = 0; k < BLOCK_CYC; k++) begin
                    @(negedge Clk);
                    checks++;
                    if (bus.req1_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL conflict_blocked_ready: cycle %0d got %b, required 0", k + 1, bus.req1_ready);
                    end
                end
            end
        join
        wait_drain();
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_busy;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            if (i >= 2) begin
                exp_busy = (16'(1) << (i - 1)) | (16'(1) << (i - 2));
                checks++;
                if (busy !== exp_busy) begin
                    errors++;
                    $display("FAIL b2b_busy: step %0d got %h, required %h", i, busy, exp_busy);
                end
            end
            bus.req0_valid = 1'b1;
            bus.req0_addr  = AW'(i);
            bus.req0_data  = 32'h100 + 32'(i);
            exp_q.push_back('{addr: AW'(i), data: 32'h100 + 32'(i)});
            checks++;
            if (bus.req0_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready: step %0d got %b, required 1", i, bus.req0_ready);
            end
            @(negedge Clk);
        end
        bus.req0_valid = 1'b0;
        wait_drain();
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (rf_mem[i] !== 32'h100 + 32'(i)) begin
                errors++;
                $display("FAIL b2b_commit: R%0d got %h, required %h", i, rf_mem[i], 32'h100 + 32'(i));
            end
        end
    endtask

    task automatic test_clr_and_saturate();
        do_reset();
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 4'd9;
        bus.req0_data  = 32'h99;
        @(negedge Clk);
        bus.req0_valid = 1'b0;
        checks++;
        if (busy !== 16'h0200) begin
            errors++;
            $display("FAIL clr_prefill_busy: got %h, required 0200", busy);
        end
        Clr = 1'b1;
        @(negedge Clk);
        Clr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rf_ld !== 1'b0 || busy !== 16'h0000) begin
                errors++;
                $display("FAIL clr_discard: cycle %0d got rf_ld=%b busy=%h, required 0 0000", k, rf_ld, busy);
            end
            @(negedge Clk);
        end
        mon_en = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_addr = 4'd1; bus.req0_data = 32'h1;
        bus.req1_valid = 1'b1; bus.req1_addr = 4'd2; bus.req1_data = 32'h2;
        repeat (300) @(negedge Clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        checks++;
        if (stall_cnt !== 8'd255) begin
            errors++;
            $display("FAIL stall_saturate: got %0d, required 255", stall_cnt);
        end
        repeat (4) @(negedge Clk);
        checks++;
        if (stall_cnt !== 8'd255 || busy !== 16'h0000) begin
            errors++;
            $display("FAIL stall_hold: got cnt=%0d busy=%h, required 255 0000", stall_cnt, busy);
        end
        mon_en = 1'b1;
        do_reset();
        checks++;
        if (stall_cnt !== 8'd0) begin
            errors++;
            $display("FAIL stall_clear: got %0d, required 0", stall_cnt);
        end
    endtask

    initial begin
        Clr = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
        bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
        for (int i = 0; i < 16; i++) rf_mem[i] = '0;
        test_reset();
        test_single();
        test_same_addr();
        test_conflict();
        test_back_to_back();
        test_clr_and_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
